seq_wide_adder_ctrl: RTL and testbench



---
 rtl/seq_wide_adder_ctrl_pkg.sv | 15 +
 rtl/seq_wide_adder_ctrl_param_adder.sv | 24 ++
 rtl/seq_wide_adder_ctrl.sv | 132 +++++++++++++
 tb/tb_seq_wide_adder_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_wide_adder_ctrl_pkg.sv
// Shared types and helpers for the sequential wide adder controller.
package seq_wide_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Slice index width: clog2 of the slice count, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_wide_adder_ctrl_param_adder.sv
// Parameterised ripple-carry adder slice.
module param_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // Bitwise ripple from LSB to MSB.
    always_comb begin
        logic carry;
        carry = i_cin;
        o_sum = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ carry;
            carry    = (i_a[i] & i_b[i]) | (carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = carry;
    end

endmodule

// File: rtl/seq_wide_adder_ctrl.sv
// Multi-cycle wide add/subtract reusing one narrow adder slice, LSB slice first.
module seq_wide_adder_ctrl
    import seq_wide_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    output logic                        o_ready,
    input  logic [WIDTH*NUM_SLICES-1:0] i_op_a,
    input  logic [WIDTH*NUM_SLICES-1:0] i_op_b,
    input  logic                        i_carry,
    input  logic                        i_sub,
    output logic                        o_valid,
    input  logic                        i_ack,
    output logic [WIDTH*NUM_SLICES-1:0] o_sum,
    output logic                        o_carry,
    output logic                        o_overflow
);

    localparam int unsigned OPW = WIDTH * NUM_SLICES;
    localparam int unsigned IW  = idx_width(NUM_SLICES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [OPW-1:0]   op_a_q, op_a_d;
    logic [OPW-1:0]   op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [OPW-1:0]   sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] a_slice, b_slice, slice_sum;
    logic             slice_cout;

    // Select the operand slices addressed by the current index.
    always_comb begin
        a_slice = op_a_q[idx_q*WIDTH +: WIDTH];
        b_slice = op_b_q[idx_q*WIDTH +: WIDTH];
    end

    param_adder #(
        .WIDTH (WIDTH)
    ) u_slice_adder (
        .i_a    (a_slice),
        .i_b    (b_slice),
        .i_cin  (carry_q),
        .o_sum  (slice_sum),
        .o_cout (slice_cout)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        o_ready = 1'b0;
        o_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    // Subtract is A + ~B + 1, so invert B and force carry-in.
                    op_a_d  = i_op_a;
                    op_b_d  = i_sub ? ~i_op_b : i_op_b;
                    carry_d = i_sub | i_carry;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*WIDTH +: WIDTH] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    ovf_d   = (op_a_q[OPW-1] == op_b_q[OPW-1]) &&
                              (sum_d[OPW-1] != op_a_q[OPW-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (i_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_sum      = sum_q;
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Scoreboard bench for seq_wide_adder_ctrl (default 4x4-bit slices).
module tb_seq_wide_adder_ctrl;

    localparam int unsigned OPW = 16;
    localparam int EXP_LAT = 4;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic           o_ready;
    logic [OPW-1:0] i_op_a = '0;
    logic [OPW-1:0] i_op_b = '0;
    logic           i_carry = 1'b0;
    logic           i_sub = 1'b0;
    logic           o_valid;
    logic           i_ack = 1'b0;
    logic [OPW-1:0] o_sum;
    logic           o_carry;
    logic           o_overflow;

    seq_wide_adder_ctrl #(
        .WIDTH      (4),
        .NUM_SLICES (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .o_ready    (o_ready),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .i_carry    (i_carry),
        .i_sub      (i_sub),
        .o_valid    (o_valid),
        .i_ack      (i_ack),
        .o_sum      (o_sum),
        .o_carry    (o_carry),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [OPW-1:0] sum;
        logic           carry;
        logic           ovf;
        int             acc_cyc;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare each newly presented result against the scoreboard head.
    logic prev_valid = 1'b0;
    always @(negedge i_clk) begin
        if (o_valid === 1'b1 && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(o_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_sum"},   32'(o_sum),      32'(e.sum));
                chk({e.name, "_carry"}, 32'(o_carry),    32'(e.carry));
                chk({e.name, "_ovf"},   32'(o_overflow), 32'(e.ovf));
                chk({e.name, "_lat"},   32'(cyc - e.acc_cyc), 32'(EXP_LAT));
            end
        end
        prev_valid = (o_valid === 1'b1);
    end

    // Issue one operation; returns at the negedge after the accepting edge.
    task automatic issue(input string name, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic cin, input logic sub,
                         input logic [OPW-1:0] es, input logic ec, input logic ev);
        exp_t e;
        int   n;
        n = 0;
        while (o_ready !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (o_ready !== 1'b1) chk({name, "_ready_timeout"}, 32'(o_ready), 32'd1);
        e.sum = es; e.carry = ec; e.ovf = ev; e.acc_cyc = cyc + 1; e.name = name;
        sb.push_back(e);
        i_op_a = a; i_op_b = b; i_carry = cin; i_sub = sub; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        // Scramble operands: only the captured copies may be used.
        i_op_a = 16'(~a); i_op_b = 16'(b ^ 16'h5A5A); i_carry = ~cin; i_sub = ~sub;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (o_valid !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (o_valid !== 1'b1) chk({name, "_valid_timeout"}, 32'(o_valid), 32'd1);
    endtask

    task automatic ack(input string name);
        i_ack = 1'b1;
        @(negedge i_clk);
        i_ack = 1'b0;
        chk({name, "_ready_after_ack"}, 32'(o_ready), 32'd1);
        chk({name, "_valid_after_ack"}, 32'(o_valid), 32'd0);
    endtask

    task automatic run(input string name, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                       input logic cin, input logic sub,
                       input logic [OPW-1:0] es, input logic ec, input logic ev);
        issue(name, a, b, cin, sub, es, ec, ev);
        wait_valid(name);
        ack(name);
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_sum",   32'(o_sum),   32'd0);
        chk("rst_carry", 32'(o_carry), 32'd0);
        chk("rst_ovf",   32'(o_overflow), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run("add_ff_1",    16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run("wrap_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run("wrap_cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run("sub_5_7",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run("sub_7_5",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run("ovf_add",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run("ovf_sub",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Hold result in DONE without ack.
        issue("hold", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        wait_valid("hold");
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_sum",   32'(o_sum),   32'h5556);
            chk("hold_carry", 32'(o_carry), 32'd0);
        end
        ack("hold");

        // Start pulses during RUN must be ignored.
        issue("start_in_run", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
        i_op_a = 16'hAAAA; i_op_b = 16'h1111; i_start = 1'b1;
        @(negedge i_clk);
        chk("run_ready", 32'(o_ready), 32'd0);
        i_start = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_valid("start_in_run");
        ack("start_in_run");
        repeat (8) @(negedge i_clk);

        // Reset at the second RUN edge abandons the operation.
        issue("rst_mid", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(o_valid), 32'd0);
        chk("rstmid_sum",   32'(o_sum),   32'd0);
        chk("rstmid_ready", 32'(o_ready), 32'd1);
        void'(sb.pop_back());
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (8) @(negedge i_clk);
        chk("rstmid_no_result", 32'(o_valid), 32'd0);

        run("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        repeat (8) @(negedge i_clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
